// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between the SPI slave's parallel side and the config register bank.
// Define SPI_CMD_PARITY_EN to enable odd-parity checking on frames and odd parity on responses.
//
// state | meaning
// IDLE  | waiting for rdy_spi, frame captured on the pulse
// DEC   | decode op/addr, classify status
// EXEC  | register write or read, response word latched
// PUSH  | waiting for spi_busy=0, push_tx strobed in the leaving cycle
// ACK   | ack_fetch_spi held until the next frame starts (spi_busy=1)
module spi_cmd_ctrl #(
  parameter int          REG_NUM     = 16,
  parameter logic [15:0] REG_RST_VAL = 16'h0,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            rx_output,
  input  logic                   rdy_spi,
  input  logic                   spi_busy,
  output logic [31:0]            tx_input,
  output logic                   push_tx,
  output logic                   ack_fetch_spi,
  output logic [REG_NUM*16-1:0]  cfg_regs,
  output logic                   cmd_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DEC  = 3'd1;
  localparam logic [2:0] EXEC = 3'd2;
  localparam logic [2:0] PUSH = 3'd3;
  localparam logic [2:0] ACK  = 3'd4;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ADDR = 2'b01;
  localparam logic [1:0] ST_RSV  = 2'b10;
  localparam logic [1:0] ST_PAR  = 2'b11;

  localparam logic [5:0]  STATUS_ADDR = 6'h3F;
  localparam logic [6:0]  REG_NUM_L   = 7'(REG_NUM);
  localparam int          AW          = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [15:0] TMO_LOAD    = 16'(TIMEOUT_CYC);

  logic [2:0]  state;
  logic [1:0]  op_q;
  logic [5:0]  addr_q;
  logic [15:0] data_q;
  logic [1:0]  st_q;
  logic [1:0]  dec_st;
  logic        addr_ok;
  logic [15:0] regs [REG_NUM];
  logic [15:0] rd_val;
  logic [15:0] status;
  logic [7:0]  ovr_cnt;
  logic        tmo_sticky;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        ovr_evt;
  logic        reg_wr;
  logic        stat_clr;
  logic [15:0] rsp_data;
  logic [31:0] rsp;

`ifdef SPI_CMD_PARITY_EN
  logic        par_q;
`else
  logic        unused_rsv;
  assign unused_rsv = ^rx_output[23:16];
`endif

  assign addr_ok  = ({1'b0, addr_q} < REG_NUM_L) || (addr_q == STATUS_ADDR);
  assign rd_val   = regs[addr_q[AW-1:0]];
  assign status   = {7'b0, tmo_sticky, ovr_cnt};
  assign ovr_evt  = rdy_spi && (state != IDLE);
  assign reg_wr   = (state == EXEC) && (op_q == OP_WR) && (st_q == ST_OK) && (addr_q != STATUS_ADDR);
  assign stat_clr = (state == EXEC) && (op_q == OP_WR) && (st_q == ST_OK) && (addr_q == STATUS_ADDR);
  assign tmo_hit  = spi_busy && (tmo_cnt == 16'd1);

  assign push_tx       = (state == PUSH) && !spi_busy;
  assign ack_fetch_spi = (state == ACK);
  assign cmd_err       = (state == EXEC) && (st_q != ST_OK);

  always_comb begin
    dec_st = ST_OK;
`ifdef SPI_CMD_PARITY_EN
    if (!par_q)
      dec_st = ST_PAR;
    else
`endif
    if (op_q == OP_RSV)
      dec_st = ST_RSV;
    else if (!addr_ok)
      dec_st = ST_ADDR;
  end

  always_comb begin
    rsp_data = 16'h0;
    if (st_q == ST_OK) begin
      case (op_q)
        OP_RD:   rsp_data = (addr_q == STATUS_ADDR) ? status : rd_val;
        OP_WR:   rsp_data = data_q;
        default: rsp_data = 16'h0;
      endcase
    end
    rsp = {st_q, addr_q, 8'h00, rsp_data};
`ifdef SPI_CMD_PARITY_EN
    rsp[23] = ~(^rsp);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_NOP;
      addr_q   <= 6'h0;
      data_q   <= 16'h0;
      st_q     <= ST_OK;
      tx_input <= 32'h0;
`ifdef SPI_CMD_PARITY_EN
      par_q    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (rdy_spi) begin
          op_q   <= rx_output[31:30];
          addr_q <= rx_output[29:24];
          data_q <= rx_output[15:0];
`ifdef SPI_CMD_PARITY_EN
          par_q  <= ^rx_output;
`endif
          state  <= DEC;
        end
        DEC: begin
          st_q  <= dec_st;
          state <= EXEC;
        end
        EXEC: begin
          tx_input <= rsp;
          state    <= PUSH;
        end
        PUSH:    if (!spi_busy) state <= ACK;
        ACK:     if (spi_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= REG_RST_VAL;
    end else if (reg_wr) begin
      regs[addr_q[AW-1:0]] <= data_q;
    end
  end

  // Down-counter reloaded while the bus is idle; terminal count flags the timeout.
  always_ff @(posedge clk) begin
    if (rst || !spi_busy)
      tmo_cnt <= TMO_LOAD;
    else if (tmo_cnt != 16'd0)
      tmo_cnt <= tmo_cnt - 16'd1;
  end

  // A status clear in the same cycle overrides a new overrun or timeout.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      ovr_cnt    <= 8'h0;
      tmo_sticky <= 1'b0;
    end else begin
      if (ovr_evt && (ovr_cnt != 8'hFF)) ovr_cnt <= ovr_cnt + 8'd1;
      if (tmo_hit) tmo_sticky <= 1'b1;
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
    assign cfg_regs[16*g +: 16] = regs[g];
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: expected response words are queued by the stimulus
// and popped by a monitor on every push_tx; direct checks cover errors, handshake and registers.
module tb_spi_cmd_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  rx_output;
  logic         rdy_spi;
  logic         spi_busy;
  logic [31:0]  tx_input;
  logic         push_tx;
  logic         ack_fetch_spi;
  logic [255:0] cfg_regs;
  logic         cmd_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cfg [16];

  spi_cmd_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rx_output     (rx_output),
    .rdy_spi       (rdy_spi),
    .spi_busy      (spi_busy),
    .tx_input      (tx_input),
    .push_tx       (push_tx),
    .ack_fetch_spi (ack_fetch_spi),
    .cfg_regs      (cfg_regs),
    .cmd_err       (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cfg(input string name);
    logic [255:0] e;
    for (int i = 0; i < 16; i++) e[16*i +: 16] = exp_cfg[i];
    checks++;
    if (cfg_regs !== e) begin
      failures++;
      $display("FAIL %s: got %064h expected %064h", name, cfg_regs, e);
    end
  endtask

  // Under the parity build, stimulus and expectations get bit 23 set for odd parity.
  function automatic logic [31:0] with_par(input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef SPI_CMD_PARITY_EN
    r[23] = 1'b0;
    r[23] = ~(^r);
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (push_tx) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_push: got %08h expected no push", tx_input);
      end else begin
        chk("tx_input", tx_input, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ovr_at: 1 = extra rdy_spi in DEC, 2 = extra rdy_spi in EXEC.
  task automatic run_frame(input logic [31:0] frame, input logic [31:0] exp_tx,
                           input logic exp_err, input int ovr_at, input int push_hold,
                           input int ack_hold, input logic bad_par);
    logic [31:0] f;
    f = with_par(frame);
    if (bad_par) f[23] = ~f[23];
    exp_q.push_back(with_par(exp_tx));
    tick(); rx_output = f; rdy_spi = 1'b1; spi_busy = 1'b0;
    tick(); rdy_spi = (ovr_at == 1);
    tick(); rdy_spi = (ovr_at == 2); spi_busy = (push_hold > 0);
    @(negedge clk); chk("cmd_err", {31'b0, cmd_err}, {31'b0, exp_err});
    repeat (push_hold) begin
      tick(); rdy_spi = 1'b0;
      @(negedge clk); chk("push_held", {31'b0, push_tx}, 32'd0);
    end
    tick(); rdy_spi = 1'b0; spi_busy = 1'b0;
    @(negedge clk); chk("push_tx", {31'b0, push_tx}, 32'd1);
    repeat (ack_hold + 1) begin
      tick();
      @(negedge clk); chk("ack_level", {31'b0, ack_fetch_spi}, 32'd1);
    end
    tick(); spi_busy = 1'b1;
    tick(); spi_busy = 1'b0;
    @(negedge clk); chk("ack_drop", {31'b0, ack_fetch_spi}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_output = 32'h0; rdy_spi = 1'b0; spi_busy = 1'b0;
    for (int i = 0; i < 16; i++) exp_cfg[i] = 16'h0;
    tick(); tick();
    @(negedge clk);
    chk("rst_tx_input", tx_input, 32'h0);
    chk("rst_push", {31'b0, push_tx}, 32'd0);
    chk("rst_ack", {31'b0, ack_fetch_spi}, 32'd0);
    chk("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
    chk_cfg("rst_cfg");
    tick(); rst = 1'b0;

    run_frame(32'hBF00_0000, 32'h3F00_0000, 1'b0, 0, 0, 0, 1'b0);
    run_frame(32'h4300_ABCD, 32'h0300_ABCD, 1'b0, 0, 0, 3, 1'b0);
    exp_cfg[3] = 16'hABCD; chk_cfg("wr_reg3");
    run_frame(32'h8300_0000, 32'h0300_ABCD, 1'b0, 0, 2, 0, 1'b0);
    run_frame(32'h9400_0000, 32'h5400_0000, 1'b1, 0, 0, 0, 1'b0);
    chk_cfg("rd_bad_addr");
    run_frame(32'h4F00_BEEF, 32'h0F00_BEEF, 1'b0, 0, 0, 0, 1'b0);
    exp_cfg[15] = 16'hBEEF; chk_cfg("wr_reg15");
    run_frame(32'h5000_1234, 32'h5000_0000, 1'b1, 0, 0, 0, 1'b0);
    chk_cfg("wr_bad_addr16");
    run_frame(32'hC200_5555, 32'h8200_0000, 1'b1, 0, 0, 0, 1'b0);
    chk_cfg("rsv_op");
    run_frame(32'h0500_1111, 32'h0500_0000, 1'b0, 0, 0, 0, 1'b0);

    run_frame(32'h4300_0000, 32'h0300_0000, 1'b0, 1, 0, 0, 1'b0);
    exp_cfg[3] = 16'h0; chk_cfg("wr_reg3_zero");
    run_frame(32'hBF00_0000, 32'h3F00_0001, 1'b0, 0, 0, 0, 1'b0);

    tick(); spi_busy = 1'b1;
    repeat (4100) tick();
    spi_busy = 1'b0;
    run_frame(32'hBF00_0000, 32'h3F00_0101, 1'b0, 0, 0, 0, 1'b0);
    run_frame(32'h7F00_1234, 32'h3F00_1234, 1'b0, 2, 0, 0, 1'b0);
    chk_cfg("status_wr_no_reg");
    run_frame(32'hBF00_0000, 32'h3F00_0000, 1'b0, 0, 0, 0, 1'b0);

`ifdef SPI_CMD_PARITY_EN
    run_frame(32'h4200_5A5A, 32'hC200_0000, 1'b1, 0, 0, 0, 1'b1);
    chk_cfg("par_err_no_write");
`endif

    tick(); rx_output = with_par(32'h4700_7777); rdy_spi = 1'b1;
    tick(); rdy_spi = 1'b0;
    tick(); spi_busy = 1'b1;
    tick();
    @(negedge clk); chk("pre_rst_push", {31'b0, push_tx}, 32'd0);
    rst = 1'b1;
    tick(); rst = 1'b0; spi_busy = 1'b0;
    @(negedge clk);
    chk("mid_rst_push", {31'b0, push_tx}, 32'd0);
    chk("mid_rst_ack", {31'b0, ack_fetch_spi}, 32'd0);
    for (int i = 0; i < 16; i++) exp_cfg[i] = 16'h0;
    chk_cfg("mid_rst_cfg");
    repeat (4) tick();
    run_frame(32'h8700_0000, 32'h0700_0000, 1'b0, 0, 0, 0, 1'b0);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
